// File: rtl/ifmap_sched_pkg.sv
// Shared types and config-word layout for the ifmap read scheduler.
package ifmap_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG1,
        ST_FILL,
        ST_SWAP,
        ST_READ,
        ST_DRAIN,
        ST_WAIT,
        ST_DONE
    } sched_state_t;

    localparam int NUM_LEVELS = 5;
    localparam int IDX_W      = 8;

    typedef logic [IDX_W-1:0]                  idx_t;
    typedef logic [NUM_LEVELS-1:0][IDX_W-1:0]  idx_vec_t;

    // Loop levels, innermost first
    localparam int LVL_IC1 = 0;
    localparam int LVL_FX  = 1;
    localparam int LVL_FY  = 2;
    localparam int LVL_OX0 = 3;
    localparam int LVL_OY0 = 4;

    // word0 fields
    localparam int OX0_LSB = 0;
    localparam int OY0_LSB = 8;
    localparam int IX0_LSB = 16;
    localparam int IY0_LSB = 24;
    localparam int DIM_W   = 8;

    // word1 fields
    localparam int IC1_LSB = 0;
    localparam int IC1_W   = 8;
    localparam int FX_LSB  = 8;
    localparam int FY_LSB  = 12;
    localparam int S_LSB   = 16;
    localparam int KERN_W  = 4;
    localparam int NB_LSB  = 20;
    localparam int NB_W    = 12;

    localparam int ADDR_CALC_W = 32;

endpackage

// File: rtl/ifmap_read_loop_counter.sv
// Five-level nested index counter; level 0 is innermost and steps on en.
module ifmap_read_loop_counter
    import ifmap_sched_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     clr,
    input  logic     en,
    input  idx_vec_t bound,
    output idx_vec_t idx,
    output logic     last
);

    logic [NUM_LEVELS-1:0] at_max;
    logic [NUM_LEVELS-1:0] carry;

    assign carry[0] = en;

    generate
        for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_level
            idx_t cnt_reg;

            assign at_max[gi] = (cnt_reg == bound[gi] - idx_t'(1));
            assign idx[gi]    = cnt_reg;

            if (gi < NUM_LEVELS - 1) begin : g_carry
                assign carry[gi+1] = carry[gi] & at_max[gi];
            end

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    cnt_reg <= '0;
                end else if (carry[gi]) begin
                    cnt_reg <= at_max[gi] ? '0 : cnt_reg + idx_t'(1);
                end
            end
        end
    endgenerate

    assign last = &at_max;

endmodule

// File: rtl/ifmap_read_scheduler.sv
// Ifmap double-buffer read scheduler: config intake, bank handshake FSM and read address stream.
// Optional stall counter port enabled by defining IFMAP_READ_PERF_CNT_EN.
module ifmap_read_scheduler
    import ifmap_sched_pkg::*;
#(
    parameter int BANK_ADDR_WIDTH = 32,
    parameter int CONFIG_WIDTH    = 32,
    parameter int CNT_WID         = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       config_en,
    input  logic [CONFIG_WIDTH-1:0]    config_data,
    input  logic                       write_bank_ready_to_switch,
    input  logic                       pe_rdy,
    output logic                       ren,
    output logic [BANK_ADDR_WIDTH-1:0] raddr,
    output logic                       rdata_vld,
    output logic                       ready_to_switch,
    output logic                       start_new_write_bank,
    output logic [CNT_WID-1:0]         bank_count,
    output logic                       layer_done,
    output logic                       config_err
`ifdef IFMAP_READ_PERF_CNT_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);

    localparam int CW1 = CNT_WID + 1;

    sched_state_t              state_reg;
    logic [CONFIG_WIDTH-1:0]   word0_reg;
    logic [CONFIG_WIDTH-1:0]   word1_reg;
    logic [CNT_WID-1:0]        banks_swapped_reg;
    logic [CNT_WID-1:0]        bank_count_reg;
    logic [CNT_WID-1:0]        bank_count_next;
    logic                      ready_to_switch_reg;
    logic                      start_new_reg;
    logic                      rdata_vld_reg;
    logic                      layer_done_reg;
    logic                      config_err_reg;

    idx_t                      ox0, oy0, ix0, iy0, ic1;
    logic [KERN_W-1:0]         fx, fy, stride;
    logic [CNT_WID-1:0]        num_banks;
    logic                      word0_zero, word1_zero;
    logic                      take_word0;
    logic                      more_banks;

    idx_vec_t                  bound;
    idx_vec_t                  idx;
    logic                      last;
    logic [ADDR_CALC_W-1:0]    row_addr;
    logic [ADDR_CALC_W-1:0]    addr_full;

    assign ox0       = word0_reg[OX0_LSB +: DIM_W];
    assign oy0       = word0_reg[OY0_LSB +: DIM_W];
    assign ix0       = word0_reg[IX0_LSB +: DIM_W];
    assign iy0       = word0_reg[IY0_LSB +: DIM_W];
    assign ic1       = word1_reg[IC1_LSB +: IC1_W];
    assign fx        = word1_reg[FX_LSB +: KERN_W];
    assign fy        = word1_reg[FY_LSB +: KERN_W];
    assign stride    = word1_reg[S_LSB +: KERN_W];
    assign num_banks = CNT_WID'(word1_reg[NB_LSB +: NB_W]);

    // word0 is already registered when word1 arrives; word1 is checked straight off the bus
    assign word0_zero = (word0_reg[OX0_LSB +: DIM_W] == '0) || (word0_reg[OY0_LSB +: DIM_W] == '0) ||
                        (word0_reg[IX0_LSB +: DIM_W] == '0) || (word0_reg[IY0_LSB +: DIM_W] == '0);
    assign word1_zero = (config_data[IC1_LSB +: IC1_W] == '0) || (config_data[FX_LSB +: KERN_W] == '0) ||
                        (config_data[FY_LSB +: KERN_W] == '0) || (config_data[S_LSB +: KERN_W] == '0) ||
                        (config_data[NB_LSB +: NB_W] == '0);

    assign take_word0      = config_en && (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign more_banks      = ({1'b0, banks_swapped_reg} + CW1'(1)) < {1'b0, num_banks};
    assign bank_count_next = bank_count_reg + CNT_WID'(1);

    assign ren = (state_reg == ST_READ) && pe_rdy;

    always_comb begin
        bound          = '0;
        bound[LVL_IC1] = ic1;
        bound[LVL_FX]  = idx_t'(fx);
        bound[LVL_FY]  = idx_t'(fy);
        bound[LVL_OX0] = ox0;
        bound[LVL_OY0] = oy0;
    end

    ifmap_read_loop_counter u_loop (
        .clk   (clk),
        .rst   (rst),
        .clr   (take_word0),
        .en    (ren),
        .bound (bound),
        .idx   (idx),
        .last  (last)
    );

    assign row_addr  = ADDR_CALC_W'(idx[LVL_IC1]) * ADDR_CALC_W'(iy0)
                     + ADDR_CALC_W'(idx[LVL_OY0]) * ADDR_CALC_W'(stride)
                     + ADDR_CALC_W'(idx[LVL_FY]);
    assign addr_full = row_addr * ADDR_CALC_W'(ix0)
                     + ADDR_CALC_W'(idx[LVL_OX0]) * ADDR_CALC_W'(stride)
                     + ADDR_CALC_W'(idx[LVL_FX]);
    assign raddr     = BANK_ADDR_WIDTH'(addr_full);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg           <= ST_IDLE;
            word0_reg           <= '0;
            word1_reg           <= '0;
            banks_swapped_reg   <= '0;
            bank_count_reg      <= '0;
            ready_to_switch_reg <= 1'b0;
            start_new_reg       <= 1'b0;
            rdata_vld_reg       <= 1'b0;
            layer_done_reg      <= 1'b0;
            config_err_reg      <= 1'b0;
        end else begin
            ready_to_switch_reg <= 1'b0;
            start_new_reg       <= 1'b0;
            rdata_vld_reg       <= ren;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (config_en) begin
                        word0_reg         <= config_data;
                        layer_done_reg    <= 1'b0;
                        bank_count_reg    <= '0;
                        banks_swapped_reg <= '0;
                        state_reg         <= ST_CFG1;
                    end
                end
                ST_CFG1: begin
                    if (config_en) begin
                        word1_reg <= config_data;
                        if (word0_zero || word1_zero) begin
                            config_err_reg <= 1'b1;
                            state_reg      <= ST_IDLE;
                        end else begin
                            config_err_reg <= 1'b0;
                            start_new_reg  <= 1'b1;
                            state_reg      <= ST_FILL;
                        end
                    end
                end
                ST_FILL, ST_WAIT: begin
                    // Pulses are set on entry so they line up with the SWAP cycle
                    if (write_bank_ready_to_switch) begin
                        ready_to_switch_reg <= 1'b1;
                        start_new_reg       <= more_banks;
                        state_reg           <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    banks_swapped_reg <= banks_swapped_reg + CNT_WID'(1);
                    state_reg         <= ST_READ;
                end
                ST_READ: begin
                    if (ren && last) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    bank_count_reg <= bank_count_next;
                    if (bank_count_next == num_banks) begin
                        layer_done_reg <= 1'b1;
                        state_reg      <= ST_DONE;
                    end else begin
                        state_reg <= ST_WAIT;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rdata_vld            = rdata_vld_reg;
    assign ready_to_switch      = ready_to_switch_reg;
    assign start_new_write_bank = start_new_reg;
    assign bank_count           = bank_count_reg;
    assign layer_done           = layer_done_reg;
    assign config_err           = config_err_reg;

`ifdef IFMAP_READ_PERF_CNT_EN
    logic [31:0] stall_cycles_reg;

    always_ff @(posedge clk) begin
        if (rst || take_word0) begin
            stall_cycles_reg <= '0;
        end else if (((state_reg == ST_READ && !pe_rdy) || state_reg == ST_FILL || state_reg == ST_WAIT)
                     && stall_cycles_reg != '1) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
`endif

endmodule
